mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
Multi-cycle sequencer between the CPU datapath and the word-wide data memory.
- Handles all load/store widths: LW, LB, LBU, LH, LHU, SW, SB, SH.
- Loads: selects the byte/half lane and applies sign or zero extension.
- SB/SH: performs read-modify-write.
- Stalls the pipeline via `stall` until the access completes.

Parameters:
ADDR_W, 32, byte-address width.
DATA_W, 32, memory word width; fixed at 32, parameterised only for port declaration.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  CPU memory request
req_ready  out  1  block can accept a request (IDLE only)
req_op  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 SW, 110 SB, 111 SH
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data; the low byte/half is used for SB/SH
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_W  extended load result; 0 for stores and errors
resp_err  out  1  misaligned access; valid while resp_valid=1
stall  out  1  pipeline hold
mem_req  out  1  memory access strobe
mem_we  out  1  write enable
mem_addr  out  ADDR_W  word-aligned address {req_addr[ADDR_W-1:2],2'b00}
mem_wdata  out  DATA_W  full write word
mem_ack  in  1  memory completion; read data is valid in the same cycle
mem_rdata  in  DATA_W  read word

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - All outputs go to 0 except req_ready=1.
  - Reset mid-operation abandons the access: no resp_valid, and mem_req is 0 in the cycle after the reset edge.
- FSM states: IDLE, RD, WR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op, addr and wdata.
  - Misaligned request (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) → RESP with err=1.
  - SW → WR.
  - All other ops → RD.
- RD:
  - Drive mem_req=1, mem_we=0, mem_addr; hold until mem_ack.
  - On ack, for loads: extract the lane, extend, register into resp_rdata, go to RESP.
  - On ack, for SB/SH: register the merged word into mem_wdata, go to WR.
- WR:
  - Drive mem_req=1, mem_we=1; hold until mem_ack, then go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - A new request is not accepted in this cycle.
- mem_addr, mem_we and mem_wdata are stable while mem_req=1.
- mem_ack is ignored in IDLE and RESP.
- Lanes are little-endian:
  - Byte k occupies bits [8k+7:8k], with k=addr[1:0].
  - The half-word is selected by addr[1].
- Extension: LB and LH sign-extend from bit 7 / bit 15; LBU and LHU zero-extend.
- Merge: SB replaces only byte k; SH replaces only half addr[1]; all other bytes come from the read word.
- stall = (IDLE && req_valid) || RD || WR. It is 0 in RESP, so the CPU advances on the resp_valid cycle.
- resp_rdata and resp_err hold their value until the next RESP.
- Minimum latency from the accept edge to resp_valid, with mem_ack in the first access cycle:
  - Loads: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Misaligned: 1 cycle.

Decomposition:
- Shared package holds:
  - Op encodings (OP_LW … OP_SH).
  - FSM state encoding.
  - Helper constants: is_load, is_sub_store, alignment mask per op.
- One combinational sub-module, load_lane_ext:
  - Inputs: word, addr[1:0], op.
  - Outputs: the extended 32-bit value and the merged store word.
- The FSM and registers live in mem_access_ctrl.

Test Plan:
1. LB and LBU, addr 0x1003, mem_rdata 0x80112233, ack on the first RD cycle → LB: resp_rdata 0xFFFFFF80; LBU: resp_rdata 0x00000080. resp_valid 2 cycles after accept, err=0.
2. LH and LHU, addr 0x0002, mem_rdata 0x80017FFF → LH: 0xFFFF8001; LHU: 0x00008001. LH at addr 0x0000 → 0x00007FFF.
3. SB addr 0x0001, wdata 0x000000AB, memory word 0x11223344 → one read to 0x0000, then a write of 0x1122AB44 with mem_we=1 only on the second access. resp_valid 3 cycles after accept.
4. SH addr 0x0001 → mem_req never asserted; resp_valid with resp_err=1 one cycle after accept; stall low in the RESP cycle.
5. LW addr 0x0010, mem_ack delayed 3 cycles → mem_req, mem_addr=0x0010 and mem_we=0 stable for 4 cycles; stall high throughout; resp_valid exactly one cycle; req_ready=1 the following cycle.
6. rst asserted during the WR phase of an SB → next cycle mem_req=0, req_ready=1, no resp_valid. A subsequent LW completes normally.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access sequencer: op codes, FSM states
// and per-op classification helpers.
package mem_access_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_LW  = 3'b000,
      OP_LB  = 3'b001,
      OP_LBU = 3'b010,
      OP_LH  = 3'b011,
      OP_LHU = 3'b100,
      OP_SW  = 3'b101,
      OP_SB  = 3'b110,
      OP_SH  = 3'b111
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RD   = 2'b01,
      ST_WR   = 2'b10,
      ST_RESP = 2'b11
   } state_t;

   localparam logic [1:0] MASK_BYTE = 2'b00;
   localparam logic [1:0] MASK_HALF = 2'b01;
   localparam logic [1:0] MASK_WORD = 2'b11;

   function automatic logic is_load(op_t op);
      return (op != OP_SW) && (op != OP_SB) && (op != OP_SH);
   endfunction

   function automatic logic is_sub_store(op_t op);
      return (op == OP_SB) || (op == OP_SH);
   endfunction

   // Address bits that must be zero for the access to be naturally aligned.
   function automatic logic [1:0] align_mask(op_t op);
      case (op)
         OP_LW, OP_SW:         return MASK_WORD;
         OP_LH, OP_LHU, OP_SH: return MASK_HALF;
         default:              return MASK_BYTE;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU request/response and data-memory bus bundle for mem_access_ctrl.
// The slave modport is the controller's view; master is the CPU+memory side.
interface mem_access_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();

   logic              req_valid;
   logic              req_ready;
   logic [2:0]        req_op;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;
   logic              stall;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, mem_ack, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err, stall,
             mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_op, req_addr, req_wdata, mem_ack, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, stall,
             mem_req, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_access_ctrl_load_lane_ext.sv
// Little-endian lane handling: extracts and extends the load lane, and merges
// the low byte/half of the store data into the word read back from memory.
module load_lane_ext
   import mem_access_ctrl_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr,
   input  op_t         op,
   input  logic [15:0] wdata,
   output logic [31:0] load_val,
   output logic [31:0] store_word
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   always_comb begin
      lane_byte  = word[{addr, 3'b000} +: 8];
      lane_half  = addr[1] ? word[31:16] : word[15:0];
      load_val   = word;
      store_word = word;

      case (op)
         OP_LB:   load_val = {{24{lane_byte[7]}}, lane_byte};
         OP_LBU:  load_val = {24'h000000, lane_byte};
         OP_LH:   load_val = {{16{lane_half[15]}}, lane_half};
         OP_LHU:  load_val = {16'h0000, lane_half};
         default: load_val = word;
      endcase

      // Only the addressed lane is replaced; the rest of the word is preserved.
      if (op == OP_SB) begin
         store_word[{addr, 3'b000} +: 8] = wdata[7:0];
      end else if (op == OP_SH) begin
         store_word[{addr[1], 4'b0000} +: 16] = wdata;
      end
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store sequencer between the CPU datapath and word-wide data
// memory; sub-word stores are done as read-modify-write.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic               clk,
   input logic               rst,
   mem_access_ctrl_if.slave  bus
);

   state_t            state;
   op_t               op_q;
   logic [1:0]        addr_lo_q;
   logic [15:0]       wdata_lo_q;
   logic [DATA_W-1:0] load_val;
   logic [DATA_W-1:0] store_word;
   op_t               req_op_c;
   logic              misaligned;

   assign req_op_c   = op_t'(bus.req_op);
   assign misaligned = (bus.req_addr[1:0] & align_mask(req_op_c)) != 2'b00;

   // The CPU is released in the RESP cycle so it advances together with resp_valid.
   assign bus.stall = ((state == ST_IDLE) && bus.req_valid) ||
                      (state == ST_RD) || (state == ST_WR);

   load_lane_ext u_lane (
      .word       (bus.mem_rdata),
      .addr       (addr_lo_q),
      .op         (op_q),
      .wdata      (wdata_lo_q),
      .load_val   (load_val),
      .store_word (store_word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         op_q           <= OP_LW;
         addr_lo_q      <= '0;
         wdata_lo_q     <= '0;
         bus.req_ready  <= 1'b1;
         bus.resp_valid <= 1'b0;
         bus.resp_rdata <= '0;
         bus.resp_err   <= 1'b0;
         bus.mem_req    <= 1'b0;
         bus.mem_we     <= 1'b0;
         bus.mem_addr   <= '0;
         bus.mem_wdata  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  op_q          <= req_op_c;
                  addr_lo_q     <= bus.req_addr[1:0];
                  wdata_lo_q    <= bus.req_wdata[15:0];
                  bus.req_ready <= 1'b0;
                  if (misaligned) begin
                     state          <= ST_RESP;
                     bus.resp_valid <= 1'b1;
                     bus.resp_err   <= 1'b1;
                     bus.resp_rdata <= '0;
                  end else begin
                     state        <= (req_op_c == OP_SW) ? ST_WR : ST_RD;
                     bus.mem_req  <= 1'b1;
                     bus.mem_we   <= (req_op_c == OP_SW);
                     bus.mem_addr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                     if (req_op_c == OP_SW) begin
                        bus.mem_wdata <= bus.req_wdata;
                     end
                  end
               end
            end

            // mem_req stays high from the read into the write of a sub-word store.
            ST_RD: begin
               if (bus.mem_ack) begin
                  if (is_load(op_q)) begin
                     state          <= ST_RESP;
                     bus.mem_req    <= 1'b0;
                     bus.resp_valid <= 1'b1;
                     bus.resp_err   <= 1'b0;
                     bus.resp_rdata <= load_val;
                  end else begin
                     state         <= ST_WR;
                     bus.mem_we    <= 1'b1;
                     bus.mem_wdata <= store_word;
                  end
               end
            end

            ST_WR: begin
               if (bus.mem_ack) begin
                  state          <= ST_RESP;
                  bus.mem_req    <= 1'b0;
                  bus.mem_we     <= 1'b0;
                  bus.resp_valid <= 1'b1;
                  bus.resp_err   <= 1'b0;
                  bus.resp_rdata <= '0;
               end
            end

            ST_RESP: begin
               state          <= ST_IDLE;
               bus.resp_valid <= 1'b0;
               bus.req_ready  <= 1'b1;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
